bpsk_awgn_channel: RTL and testbench
====================================

BPSK_AWGN_CHANNEL -- requirements
Module: bpsk_awgn_channel

Interface
REQ-001 SHALL provide parameter SPS, default 8, output samples per BPSK symbol (range 2..256).
REQ-002 SHALL provide parameter AMP, default 8192, signed 16-bit symbol amplitude (range 1..32767).
REQ-003 SHALL provide port clk, input, 1, single clock (the divided data clock).
REQ-004 SHALL provide port n_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port enable, input, 1, global run enable.
REQ-006 SHALL provide port bit_in, input, 1, data bit to modulate.
REQ-007 SHALL provide port bit_valid, input, 1, bit_in is valid.
REQ-008 SHALL provide port bit_ready, output, 1, block accepts bit_in this cycle.
REQ-009 SHALL provide port noise_in, input, 16 signed, Gaussian noise sample from the LFSR_Plus noise generator.
REQ-010 SHALL provide port noise_shift, input, 2, noise attenuation as an arithmetic right shift of 0..3.
REQ-011 SHALL provide port sample_out, output, 16 signed, noisy BPSK sample.
REQ-012 SHALL provide port sample_valid, output, 1, sample_out valid.
REQ-013 SHALL provide port symbol_start, output, 1, sample_out is the first sample of a symbol.
REQ-014 SHALL provide port sat_count, output, 16, count of clamped samples.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and RUN, plus a symbol register (+AMP for bit 1, -AMP for bit 0) and a sample counter cnt (0..SPS-1).
REQ-016 SHALL drive bit_ready = enable AND (state==IDLE OR (state==RUN AND cnt==SPS-1)), combinationally.
REQ-017 SHALL complete a handshake when bit_valid AND bit_ready are high at a rising edge; on that edge it latches the symbol, sets cnt=0 and enters RUN.
REQ-018 SHALL, on every edge in RUN with enable=1, register sample_out = sat16(symbol + (noise_in >>> noise_shift)), drive sample_valid=1, and increment cnt.
REQ-019 SHALL compute the sum at 17-bit signed width and clamp it to [-32768, 32767].
REQ-020 SHALL assert symbol_start together with the sample registered when cnt==0, and SHALL hold it low otherwise.
REQ-021 SHALL, at cnt==SPS-1:
  - if a handshake occurs, load the new symbol with cnt=0 and stay in RUN, so the back-to-back sample stream has no gap;
  - otherwise go to IDLE.
REQ-022 SHALL emit exactly SPS valid samples per accepted bit; the first sample appears one edge after the handshake edge.
REQ-023 SHALL, with enable=0, freeze state, cnt and symbol, drive sample_valid=0 and symbol_start=0, and hold sample_out at its last value.
REQ-024 SHALL drive sample_valid=0 in IDLE.
REQ-025 SHALL sample noise_in every RUN cycle, with no handshake on the noise path.

Reset
REQ-026 SHALL, on n_reset low and asynchronously, set the state to IDLE, cnt=0, symbol=0, sample_out=0, sample_valid=0, symbol_start=0 and sat_count=0.
REQ-027 SHALL discard a symbol that is in progress when reset is asserted mid-symbol; no partial symbol resumes after reset.

Configuration
REQ-028 SHALL, with macro AWGN_SAT_COUNT_EN defined, increment sat_count by 1 on each registered sample that was clamped, saturating at 65535.
REQ-029 SHALL, without AWGN_SAT_COUNT_EN, tie sat_count to 0; clamping per REQ-019 is still performed.

Verification
REQ-030 SHALL verify: SPS=8, AMP=8192, noise_in=0, bit_in=1 handshake -> 8 samples of 8192, symbol_start on the first only, bit_ready low for cnt 0..6, then IDLE.
REQ-031 SHALL verify: bit_in=0, noise_in=100, noise_shift=0 -> 8 samples of -8092; the same with noise_shift=2 -> -8167.
REQ-032 SHALL verify: bit_in=1, noise_in=32767, noise_shift=0 -> 8 samples of 32767; sat_count=8 with the macro defined and 0 without it.
REQ-033 SHALL verify: bits 1 then 0 with bit_valid held high -> 16 contiguous valid samples (8192 x8 then -8192 x8), symbol_start on samples 1 and 9.
REQ-034 SHALL verify: enable low for 5 cycles after sample 3 -> sample_valid low for 5 cycles, then the remaining 5 samples, 8 in total.
REQ-035 SHALL verify: n_reset pulsed low after sample 4 -> all outputs 0 immediately; after release with enable=1, bit_ready=1 and no further samples appear without a new handshake.

Source files
------------

// File: rtl/bpsk_awgn_channel.sv
// BPSK modulator with additive noise: SPS saturated samples of +/-AMP plus scaled noise per accepted bit.
// Optional feature: define AWGN_SAT_COUNT_EN to enable the clamped-sample counter on sat_count.
module bpsk_awgn_channel #(
  parameter int SPS = 8,
  parameter int AMP = 8192
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               enable,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic signed [15:0] noise_in,
  input  logic [1:0]         noise_shift,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               symbol_start,
  output logic [15:0]        sat_count
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic signed [15:0] POS = 16'(AMP);
  localparam logic signed [15:0] NEG = -POS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic signed [15:0]  symbol;
  logic signed [15:0]  noise_sh;
  logic [16:0]         sum;
  logic                clamped;
  logic [15:0]         sat_val;
  logic                at_last;
  logic                handshake;
  logic                running;

  assign at_last  = (cnt == LAST);
  assign running  = enable && (state == RUN);
  assign noise_sh = noise_in >>> noise_shift;
  assign sum      = {symbol[15], symbol} + {noise_sh[15], noise_sh};

  // Overflow of the 17-bit sum shows up as disagreement of its top two bits.
  assign clamped  = sum[16] ^ sum[15];
  assign sat_val  = clamped ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    bit_ready = enable && ((state == IDLE) || ((state == RUN) && at_last));
    handshake = bit_valid && bit_ready;
    state_nx  = state;
    if (enable) begin
      case (state)
        IDLE:    if (handshake) state_nx = RUN;
        RUN:     if (at_last && !handshake) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // A handshake on the last sample reloads the symbol on the same edge, so the stream has no gap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt          <= '0;
      symbol       <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      symbol_start <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      symbol_start <= 1'b0;
      if (running) begin
        sample_out   <= sat_val;
        sample_valid <= 1'b1;
        symbol_start <= (cnt == '0);
        cnt          <= at_last ? '0 : cnt + CW'(1);
      end
      if (handshake) begin
        symbol <= bit_in ? POS : NEG;
        cnt    <= '0;
      end
    end
  end

`ifdef AWGN_SAT_COUNT_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      sat_count <= '0;
    else if (running && clamped && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_bpsk_awgn_channel.sv
// Scoreboard bench for bpsk_awgn_channel: expected samples are queued at each handshake and popped as samples appear.
module tb_bpsk_awgn_channel;

  localparam int SPS = 8;
  localparam int AMP = 8192;

  typedef struct {
    int value;
    bit start;
  } exp_t;

  logic               clk;
  logic               n_reset;
  logic               enable;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] noise_in;
  logic [1:0]         noise_shift;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               symbol_start;
  logic [15:0]        sat_count;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   samples_seen = 0;
  int   valid_run = 0;
  int   max_run = 0;
  int   sat_exp = 0;

  bpsk_awgn_channel #(.SPS(SPS), .AMP(AMP)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enable       (enable),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .noise_in     (noise_in),
    .noise_shift  (noise_shift),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .symbol_start (symbol_start),
    .sat_count    (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_sample(input logic b, input logic signed [15:0] n, input logic [1:0] sh);
    int v;
    v = (b ? AMP : -AMP) + (int'(n) >>> sh);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic bit model_clamps(input logic b, input logic signed [15:0] n, input logic [1:0] sh);
    int v;
    v = (b ? AMP : -AMP) + (int'(n) >>> sh);
    return (v > 32767) || (v < -32768);
  endfunction

  // Called at a negedge; waits for bit_ready, queues SPS expected samples, then lets the handshake edge pass.
  task automatic applyStimulus(input logic b, input logic signed [15:0] n, input logic [1:0] sh, input bit hold_valid);
    int   waited = 0;
    exp_t e;
    bit_in      = b;
    noise_in    = n;
    noise_shift = sh;
    bit_valid   = 1'b1;
    while (!bit_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        checkOutput("ready_timeout", waited, 0);
        bit_valid = 1'b0;
        return;
      end
    end
    for (int i = 0; i < SPS; i++) begin
      e.value = model_sample(b, n, sh);
      e.start = (i == 0);
      sb.push_back(e);
      if (model_clamps(b, n, sh)) sat_exp++;
    end
    @(negedge clk);
    if (!hold_valid) bit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || sample_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic wait_samples(input int target);
    int n = 0;
    while (samples_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_samples", samples_seen, target);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (n_reset) begin
      if (sample_valid) begin
        samples_seen++;
        valid_run++;
        if (valid_run > max_run) max_run = valid_run;
        if (sb.size() == 0) begin
          checkOutput("unexpected_sample", int'(sample_out), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("sample_out", int'(sample_out), e.value);
          checkOutput("symbol_start", int'(symbol_start), int'(e.start));
        end
      end else begin
        valid_run = 0;
        if (symbol_start) checkOutput("stray_start", 1, 0);
      end
    end
  end

  initial begin
    int base;
    n_reset     = 1'b0;
    enable      = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    noise_in    = '0;
    noise_shift = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sample_out", int'(sample_out), 0);
    checkOutput("rst_sample_valid", int'(sample_valid), 0);
    checkOutput("rst_symbol_start", int'(symbol_start), 0);
    checkOutput("rst_sat_count", int'(sat_count), 0);
    n_reset = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", int'(bit_ready), 1);

    // Clean +AMP symbol, with bit_ready low for cnt 0..6.
    applyStimulus(1'b1, 16'sd0, 2'd0, 1'b0);
    for (int i = 0; i < SPS - 1; i++) begin
      checkOutput("ready_mid_symbol", int'(bit_ready), 0);
      @(negedge clk);
    end
    checkOutput("ready_last", int'(bit_ready), 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_valid", int'(sample_valid), 0);
    checkOutput("idle_ready_again", int'(bit_ready), 1);
    wait_idle("clean");
    checkOutput("clean_count", samples_seen, 8);

    // Noise scaling and saturation cases.
    applyStimulus(1'b0, 16'sd100, 2'd0, 1'b0);
    wait_idle("noise_s0");
    applyStimulus(1'b0, 16'sd100, 2'd2, 1'b0);
    wait_idle("noise_s2");
    applyStimulus(1'b0, -16'sd100, 2'd3, 1'b0);
    wait_idle("noise_neg_s3");
    applyStimulus(1'b1, 16'sd32767, 2'd0, 1'b0);
    wait_idle("sat_pos");
    checkOutput("sat_pos_value", int'(sample_out), 32767);
    applyStimulus(1'b0, -16'sd32768, 2'd0, 1'b0);
    wait_idle("sat_neg");
    checkOutput("sat_neg_value", int'(sample_out), -32768);
`ifdef AWGN_SAT_COUNT_EN
    checkOutput("sat_count", int'(sat_count), sat_exp);
`else
    checkOutput("sat_count", int'(sat_count), 0);
`endif

    // Back-to-back symbols must form one contiguous 16-sample burst.
    max_run = 0;
    base = samples_seen;
    applyStimulus(1'b1, 16'sd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 16'sd0, 2'd0, 1'b0);
    wait_idle("b2b");
    checkOutput("b2b_count", samples_seen - base, 16);
    checkOutput("b2b_contiguous", max_run, 16);

    // Enable low for five cycles after the third sample.
    base = samples_seen;
    applyStimulus(1'b1, 16'sd0, 2'd0, 1'b0);
    wait_samples(base + 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("freeze_valid", int'(sample_valid), 0);
      checkOutput("freeze_hold", int'(sample_out), AMP);
    end
    enable = 1'b1;
    wait_idle("freeze");
    checkOutput("freeze_count", samples_seen - base, 8);

    // Reset mid-symbol discards the rest of the symbol.
    base = samples_seen;
    applyStimulus(1'b1, 16'sd0, 2'd0, 1'b0);
    wait_samples(base + 4);
    n_reset = 1'b0;
    #1;
    checkOutput("mid_rst_sample_out", int'(sample_out), 0);
    checkOutput("mid_rst_valid", int'(sample_valid), 0);
    checkOutput("mid_rst_start", int'(symbol_start), 0);
    checkOutput("mid_rst_sat", int'(sat_count), 0);
    sb.delete();
    sat_exp = 0;
    @(negedge clk);
    n_reset = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", int'(bit_ready), 1);
    base = samples_seen;
    repeat (12) @(negedge clk);
    checkOutput("post_rst_no_samples", samples_seen - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
